// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART byte writer among N_REQ requesters; grant registered one cycle after req with writer ready.
// Stalls while the writer is busy; define UART_ARB_TIMEOUT_EN to abort a stuck byte after TIMEOUT cycles in S_WAIT.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   ack_o,
  input  logic               uart_ready_i,
  output logic               uart_send_o,
  input  logic               uart_finish_i,
  output logic [7:0]         uart_data_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] owner_nxt;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand_idx;
  logic [PTR_W:0]   cand;
  logic             win_vld;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             send_q, send_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;
  logic             grant;
  logic             wait_done;
  logic             timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside S_WAIT, so every entry starts a fresh count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q != S_WAIT) begin
      cnt_q <= '0;
    end else if (!timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  // Rotating priority search starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N_REQ)) begin
        cand = cand - (PTR_W+1)'(N_REQ);
      end
      cand_idx = cand[PTR_W-1:0];
      if (!win_vld && req_i[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign grant     = (state_q == S_IDLE) && uart_ready_i && win_vld;
  assign wait_done = (state_q == S_WAIT) && (uart_finish_i || timeout_hit);
  assign owner_nxt = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant)         state_d = S_START;
      S_START: if (!uart_ready_i) state_d = S_WAIT;
      S_WAIT:  if (wait_done)     state_d = S_DONE;
      S_DONE:                     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Writer edge-detects send, so it is held until ready falls and kept low for the whole byte.
  always_comb begin
    ack_d   = '0;
    err_d   = 1'b0;
    send_d  = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          owner_d = win_idx;
          data_d  = req_data_i[{win_idx, 3'b000} +: 8];
          send_d  = 1'b1;
        end
      end
      S_START: send_d = uart_ready_i;
      S_WAIT: begin
        if (wait_done) begin
          ack_d[owner_q] = 1'b1;
          err_d          = timeout_hit && !uart_finish_i;
          ptr_d          = owner_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      ack_q   <= ack_d;
      send_q  <= send_d;
      data_q  <= data_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ack_o       = ack_q;
  assign uart_send_o = send_q;
  assign uart_data_o = data_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter; the bench plays the UART writer and predicts grants from a pointer model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           uart_ready;
  logic           uart_send;
  logic           uart_finish;
  logic [7:0]     uart_data;
  logic           busy;
  logic           err;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m    = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .req_data_i   (req_data),
    .ack_o        (ack),
    .uart_ready_i (uart_ready),
    .uart_send_o  (uart_send),
    .uart_finish_i(uart_finish),
    .uart_data_o  (uart_data),
    .busy_o       (busy),
    .err_o        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // First pending requester at or after the pointer, wrapping around.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Writer model: accepts the byte, runs a random byte time, pulses finish, expects the ack.
  task automatic serve(input int port, input string tag, input bit stop_in_wait, output bit ok);
    logic [7:0] exp_b;
    bit         seen;
    bit         stray;
    int         hold;
    int         btime;
    exp_b = req_data[8*port +: 8];
    seen  = 1'b0;
    ok    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = uart_send;
    end
    check({tag, "_send_rise"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_data"}, 32'(uart_data), 32'(exp_b));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    hold  = $urandom_range(0, 2);
    stray = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (uart_send !== 1'b1) stray = 1'b1;
    end
    check({tag, "_send_held"}, 32'(stray), 32'd0);
    uart_ready = 1'b0;
    @(negedge clk);
    check({tag, "_send_drop"}, 32'(uart_send), 32'd0);
    ok = 1'b1;
    if (stop_in_wait) return;
    btime = $urandom_range(1, 5);
    stray = 1'b0;
    for (int i = 0; i < btime; i++) begin
      @(negedge clk);
      if (uart_send !== 1'b0 || ack !== '0) stray = 1'b1;
    end
    check({tag, "_quiet_wait"}, 32'(stray), 32'd0);
    uart_finish = 1'b1;
    @(negedge clk);
    uart_finish = 1'b0;
    check({tag, "_ack"}, 32'(ack), 32'(onehot(port)));
    check({tag, "_err"}, 32'(err), 32'd0);
    req[port]  = 1'b0;
    uart_ready = 1'b1;
    ptr_m      = (port + 1) % N;
    @(negedge clk);
    check({tag, "_ack_clear"}, 32'(ack), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           ok;
    bit           stray;
    int           p;
    logic [N-1:0] newbits;

    rst_n       = 1'b0;
    req         = '0;
    req_data    = '0;
    uart_ready  = 1'b1;
    uart_finish = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack",  32'(ack),       32'd0);
    check("rst_send", 32'(uart_send), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    check("rst_busy", 32'(busy),      32'd0);
    check("rst_err",  32'(err),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'(busy), 32'd0);

    // Writer not ready: no grant; a stray finish in idle must be ignored.
    uart_ready       = 1'b0;
    req_data[7:0]    = 8'h3C;
    req              = 4'b0001;
    repeat (4) @(negedge clk);
    check("notready_send", 32'(uart_send), 32'd0);
    check("notready_busy", 32'(busy),      32'd0);
    uart_finish = 1'b1;
    @(negedge clk);
    uart_finish = 1'b0;
    @(negedge clk);
    check("stray_finish_ack", 32'(ack), 32'd0);
    uart_ready = 1'b1;
    serve(pick(req, ptr_m), "notready", 1'b0, ok);

    req_data[15:8] = 8'hA5;
    req            = 4'b0010;
    serve(pick(req, ptr_m), "single", 1'b0, ok);

    req_data[31:24] = 8'h5A;
    req_data[7:0]   = 8'hC3;
    req             = 4'b1001;
    serve(pick(req, ptr_m), "ptr_first", 1'b0, ok);
    serve(pick(req, ptr_m), "ptr_second", 1'b0, ok);

    // All requesters stay busy and re-raise after their ack.
    req_data = 32'h44332211;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      p = pick(req, ptr_m);
      serve(p, "rr", 1'b0, ok);
      req[p] = 1'b1;
    end

    for (int it = 0; it < 30; it++) begin
      if (req == '0) begin
        newbits = 4'($urandom_range(1, 15));
        for (int b = 0; b < N; b++) if (newbits[b]) req_data[8*b +: 8] = 8'($urandom);
        req = newbits;
      end
      p = pick(req, ptr_m);
      serve(p, "rand", 1'b0, ok);
      newbits = 4'($urandom) & ~req;
      for (int b = 0; b < N; b++) if (newbits[b]) req_data[8*b +: 8] = 8'($urandom);
      req = req | newbits;
    end
    req = '0;
    @(negedge clk);

    // Drive the pointer to 3, then reset mid-byte and confirm the search restarts at 0.
    req_data[23:16] = 8'h96;
    req             = 4'b0100;
    serve(pick(req, ptr_m), "pre_rst", 1'b0, ok);
    req_data[31:24] = 8'hE7;
    req             = 4'b1000;
    serve(pick(req, ptr_m), "rst_wait", 1'b1, ok);
    #2 rst_n = 1'b0;
    #1;
    check("arst_send", 32'(uart_send), 32'd0);
    check("arst_busy", 32'(busy),      32'd0);
    check("arst_data", 32'(uart_data), 32'd0);
    check("arst_ack",  32'(ack),       32'd0);
    req = '0;
    @(negedge clk);
    uart_ready  = 1'b1;
    uart_finish = 1'b1;
    @(negedge clk);
    uart_finish = 1'b0;
    check("arst_hold_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    ptr_m = 0;
    req_data[23:16] = 8'h4B;
    req             = 4'b1100;
    serve(pick(req, ptr_m), "post_rst", 1'b0, ok);
    req = '0;
    @(negedge clk);

    // Writer never finishes.
    req_data[15:8] = 8'h81;
    req            = 4'b0010;
    p              = pick(req, ptr_m);
    serve(p, "stuck", 1'b1, ok);
    stray = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      @(negedge clk);
      if (ack !== '0 || err !== 1'b0) stray = 1'b1;
    end
    check("to_early", 32'(stray), 32'd0);
    @(negedge clk);
    check("to_ack", 32'(ack), 32'(onehot(p)));
    check("to_err", 32'(err), 32'd1);
    req        = '0;
    uart_ready = 1'b1;
    ptr_m      = (p + 1) % N;
    @(negedge clk);
    check("to_ack_clear", 32'(ack),  32'd0);
    check("to_err_clear", 32'(err),  32'd0);
    check("to_idle",      32'(busy), 32'd0);
`else
    for (int k = 0; k < 3 * TO; k++) begin
      @(negedge clk);
      if (ack !== '0 || err !== 1'b0 || busy !== 1'b1) stray = 1'b1;
    end
    check("no_to_stuck", 32'(stray), 32'd0);
    uart_finish = 1'b1;
    @(negedge clk);
    uart_finish = 1'b0;
    check("no_to_ack", 32'(ack), 32'(onehot(p)));
    check("no_to_err", 32'(err), 32'd0);
    req        = '0;
    uart_ready = 1'b1;
    ptr_m      = (p + 1) % N;
    @(negedge clk);
    check("no_to_idle", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
